// File: rtl/vga_driver.sv
// vga_driver: 640x480@60 VGA timing from a 50 MHz clock with a 25 MHz pixel enable.
// Mode 0 fills the screen with a latched colour; mode 1 draws a button-steered 32x32 white square.
module vga_driver (
    input  logic sysclk,
    input  logic rst_n,
    input  logic change_button,
    input  logic R,
    input  logic G,
    input  logic B,
    input  logic set,
    input  logic North,
    input  logic South,
    input  logic East,
    input  logic West,
    output logic VGA_R,
    output logic VGA_G,
    output logic VGA_B,
    output logic VGA_HS,
    output logic VGA_VS
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [9:0] SQ_SIZE    = 10'd32;
    localparam logic [9:0] SQ_STEP    = 10'd16;
    localparam logic [9:0] SQ_X_MAX   = 10'd608;
    localparam logic [9:0] SQ_Y_MAX   = 10'd448;
    localparam logic [9:0] SQ_X_RESET = 10'd304;
    localparam logic [9:0] SQ_Y_RESET = 10'd224;

    localparam int unsigned IDX_CHANGE = 8;
    localparam int unsigned IDX_R      = 7;
    localparam int unsigned IDX_B      = 5;
    localparam int unsigned IDX_SET    = 4;
    localparam int unsigned IDX_NORTH  = 3;
    localparam int unsigned IDX_SOUTH  = 2;
    localparam int unsigned IDX_EAST   = 1;
    localparam int unsigned IDX_WEST   = 0;

    typedef enum logic {
        MODE_FILL   = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    logic [8:0] async_in;
    logic [8:0] sync1_q, sync1_d;
    logic [8:0] sync2_q, sync2_d;
    logic [8:0] prev_q, prev_d;
    logic [8:0] rise;

    logic       pix_en_q, pix_en_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    mode_e      mode_q, mode_d;
    logic [2:0] colour_q, colour_d;
    logic [9:0] sq_x_q, sq_x_d;
    logic [9:0] sq_y_q, sq_y_d;

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [2:0] rgb_q, rgb_d;
    logic       visible;
    logic       in_square;
    logic [2:0] pixel;

    assign async_in = {change_button, R, G, B, set, North, South, East, West};

    // Two-stage synchronizer followed by a one-register rising-edge detector.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
    end

    always_comb begin
        mode_d   = mode_q;
        colour_d = colour_q;
        sq_x_d   = sq_x_q;
        sq_y_d   = sq_y_q;

        if (rise[IDX_CHANGE]) begin
            mode_d = (mode_q == MODE_FILL) ? MODE_SQUARE : MODE_FILL;
        end
        if (rise[IDX_SET]) begin
            colour_d = sync2_q[IDX_R:IDX_B];
        end

        // Opposing edges in the same cycle cancel; moves saturate at the screen bounds.
        if (mode_q == MODE_SQUARE) begin
            if (rise[IDX_NORTH] && !rise[IDX_SOUTH]) begin
                sq_y_d = (sq_y_q < SQ_STEP) ? '0 : sq_y_q - SQ_STEP;
            end else if (rise[IDX_SOUTH] && !rise[IDX_NORTH]) begin
                sq_y_d = (sq_y_q > SQ_Y_MAX - SQ_STEP) ? SQ_Y_MAX : sq_y_q + SQ_STEP;
            end
            if (rise[IDX_WEST] && !rise[IDX_EAST]) begin
                sq_x_d = (sq_x_q < SQ_STEP) ? '0 : sq_x_q - SQ_STEP;
            end else if (rise[IDX_EAST] && !rise[IDX_WEST]) begin
                sq_x_d = (sq_x_q > SQ_X_MAX - SQ_STEP) ? SQ_X_MAX : sq_x_q + SQ_STEP;
            end
        end
    end

    always_comb begin
        pix_en_d = ~pix_en_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        visible   = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
        in_square = (h_cnt_q >= sq_x_q) && (h_cnt_q < sq_x_q + SQ_SIZE) &&
                    (v_cnt_q >= sq_y_q) && (v_cnt_q < sq_y_q + SQ_SIZE);
        pixel     = '0;
        if (visible) begin
            if (mode_q == MODE_SQUARE) begin
                pixel = in_square ? '1 : '0;
            end else begin
                pixel = colour_q;
            end
        end

        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (pix_en_q) begin
            hs_d  = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
            vs_d  = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
            rgb_d = pixel;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            mode_q   <= MODE_FILL;
            colour_q <= '0;
            sq_x_q   <= SQ_X_RESET;
            sq_y_q   <= SQ_Y_RESET;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            pix_en_q <= pix_en_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            mode_q   <= mode_d;
            colour_q <= colour_d;
            sq_x_q   <= sq_x_d;
            sq_y_q   <= sq_y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            rgb_q    <= rgb_d;
        end
    end

    assign VGA_R  = rgb_q[2];
    assign VGA_G  = rgb_q[1];
    assign VGA_B  = rgb_q[0];
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver: a raster-position model derived from elapsed sysclk edges checks
// outputs and state every cycle; directed scenarios add hand-computed literal checks.
`timescale 1ns/1ps
module tb_vga_driver;

    logic sysclk = 1'b0;
    logic rst_n = 1'b0;
    logic change_button = 1'b0;
    logic r_sw = 1'b0, g_sw = 1'b0, b_sw = 1'b0;
    logic set_btn = 1'b0;
    logic north = 1'b0, south = 1'b0, east = 1'b0, west = 1'b0;
    logic VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    vga_driver dut (
        .sysclk(sysclk), .rst_n(rst_n), .change_button(change_button),
        .R(r_sw), .G(g_sw), .B(b_sw), .set(set_btn),
        .North(north), .South(south), .East(east), .West(west),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
    );

    always #10 sysclk = ~sysclk;

    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: k = sysclk edges since reset release; the pixel clock advances on even
    // edges, so after k edges the raster position is k/2 and outputs show pixel k/2-1.
    int k;
    logic [8:0] smp1, smp2, smp3;
    int m_mode, m_col, m_sqx, m_sqy;
    logic m_hs, m_vs;
    logic [2:0] m_rgb;
    int out_h, out_v;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        k = 0;
        smp1 = '0; smp2 = '0; smp3 = '0;
        m_mode = 0; m_col = 0; m_sqx = 304; m_sqy = 224;
        m_hs = 1'b1; m_vs = 1'b1; m_rgb = 3'b000;
        out_h = -1; out_v = -1;
    endtask

    task automatic model_step();
        logic [8:0] pins;
        logic [8:0] edges;
        int q, h, v;
        pins  = {change_button, r_sw, g_sw, b_sw, set_btn, north, south, east, west};
        // A pin edge sampled two edges ago is acted on at this edge.
        edges = smp2 & ~smp3;
        k++;
        if (k % 2 == 0) begin
            q = k / 2 - 1;
            h = q % 800;
            v = (q / 800) % 525;
            m_hs = !(h >= 656 && h <= 751);
            m_vs = !(v == 490 || v == 491);
            if (h < 640 && v < 480) begin
                if (m_mode == 1)
                    m_rgb = (h >= m_sqx && h < m_sqx + 32 && v >= m_sqy && v < m_sqy + 32) ? 3'b111 : 3'b000;
                else
                    m_rgb = 3'(m_col);
            end else begin
                m_rgb = 3'b000;
            end
            out_h = h;
            out_v = v;
        end
        if (m_mode == 1) begin
            if (edges[3] && !edges[2]) m_sqy = imax(m_sqy - 16, 0);
            if (edges[2] && !edges[3]) m_sqy = imin(m_sqy + 16, 448);
            if (edges[0] && !edges[1]) m_sqx = imax(m_sqx - 16, 0);
            if (edges[1] && !edges[0]) m_sqx = imin(m_sqx + 16, 608);
        end
        if (edges[4]) m_col = int'(smp2[7:5]);
        if (edges[8]) m_mode = 1 - m_mode;
        smp3 = smp2;
        smp2 = smp1;
        smp1 = pins;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sysclk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        int p;
        @(negedge sysclk);
        p = k / 2;
        check("outputs", {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, {m_hs, m_vs, m_rgb});
        check("h_cnt", dut.h_cnt_q, p % 800);
        check("v_cnt", dut.v_cnt_q, (p / 800) % 525);
        check("mode", int'(dut.mode_q), m_mode);
        check("colour", dut.colour_q, m_col);
        check("sq_pos", {dut.sq_x_q, dut.sq_y_q}, {10'(m_sqx), 10'(m_sqy)});
    end

    task automatic pulse(input logic chg, input logic st, input logic n, input logic s,
                         input logic e, input logic w);
        @(negedge sysclk);
        change_button = chg; set_btn = st; north = n; south = s; east = e; west = w;
        @(negedge sysclk);
        change_button = 1'b0; set_btn = 1'b0; north = 1'b0; south = 1'b0; east = 1'b0; west = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic wait_hs(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge sysclk);
            if (VGA_HS == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_pix(input string name, input int x, input int y, input logic [2:0] want);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge sysclk);
            if (out_h == x && out_v == y) begin
                found = 1'b1;
                break;
            end
        end
        if (found) check(name, {VGA_R, VGA_G, VGA_B}, want);
        else check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        bit ok;
        int t0, t1, t2, line;

        repeat (3) @(negedge sysclk);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("rst_h_cnt", dut.h_cnt_q, 0);
        check("rst_v_cnt", dut.v_cnt_q, 0);
        check("rst_mode", int'(dut.mode_q), 0);
        check("rst_colour", dut.colour_q, 0);
        check("rst_sq_x", dut.sq_x_q, 304);
        check("rst_sq_y", dut.sq_y_q, 224);
        rst_n = 1'b1;

        wait_hs(1'b0, ok); check("hs_fall1_seen", ok, 1); t0 = cyc;
        wait_hs(1'b1, ok); check("hs_rise_seen", ok, 1); t1 = cyc;
        wait_hs(1'b0, ok); check("hs_fall2_seen", ok, 1); t2 = cyc;
        check("hs_low_sysclk", t1 - t0, 192);
        check("hs_period_sysclk", t2 - t0, 1600);

        r_sw = 1'b1; b_sw = 1'b1;
        pulse(0, 1, 0, 0, 0, 0);
        check("colour_set_101", dut.colour_q, 5);
        line = out_v + 1;
        check_pix("mode0_visible_101", 100, line, 3'b101);
        check_pix("mode0_hblank_000", 700, line, 3'b000);

        pulse(1, 0, 0, 0, 0, 0);
        check("mode_toggle_to_1", int'(dut.mode_q), 1);

        pulse(0, 0, 1, 0, 0, 0); check("north_sq_y", dut.sq_y_q, 208);
        pulse(0, 0, 0, 1, 0, 0); check("south_sq_y", dut.sq_y_q, 224);
        pulse(0, 0, 1, 1, 0, 0); check("ns_cancel_sq_y", dut.sq_y_q, 224);
        pulse(0, 0, 1, 0, 0, 1);
        check("nw_sq_x", dut.sq_x_q, 288);
        check("nw_sq_y", dut.sq_y_q, 208);
        pulse(0, 0, 0, 1, 1, 0);
        check("se_sq_x", dut.sq_x_q, 304);
        check("se_sq_y", dut.sq_y_q, 224);

        for (int i = 0; i < 20; i++) pulse(0, 0, 0, 0, 0, 1);
        check("west20_sq_x", dut.sq_x_q, 0);
        pulse(0, 0, 0, 0, 0, 1);
        check("west_at_min_sq_x", dut.sq_x_q, 0);
        for (int i = 0; i < 40; i++) pulse(0, 0, 0, 0, 1, 0);
        check("east40_sq_x", dut.sq_x_q, 608);
        for (int i = 0; i < 19; i++) pulse(0, 0, 0, 0, 0, 1);
        check("west19_sq_x", dut.sq_x_q, 304);
        for (int i = 0; i < 14; i++) pulse(0, 0, 1, 0, 0, 0);
        check("north14_sq_y", dut.sq_y_q, 0);

        check_pix("sq_left_outside", 303, 8, 3'b000);
        check_pix("sq_left_inside", 304, 8, 3'b111);
        check_pix("sq_right_inside", 335, 31, 3'b111);
        check_pix("sq_right_outside", 336, 31, 3'b000);
        check_pix("sq_below_outside", 304, 32, 3'b000);

        pulse(0, 0, 0, 1, 0, 0); check("south_from_top_sq_y", dut.sq_y_q, 16);
        pulse(1, 0, 0, 0, 0, 0); check("mode_toggle_to_0", int'(dut.mode_q), 0);
        pulse(0, 0, 1, 0, 0, 0); check("mode0_north_ignored", dut.sq_y_q, 16);
        pulse(0, 0, 0, 0, 0, 1); check("mode0_west_ignored", dut.sq_x_q, 304);

        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (out_h == 400) begin
                ok = 1'b1;
                break;
            end
        end
        check("midline_reached", ok, 1);
        check("pre_reset_rgb_101", {VGA_R, VGA_G, VGA_B}, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hs", VGA_HS, 1);
        check("async_rst_vs", VGA_VS, 1);
        check("async_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("async_rst_h_cnt", dut.h_cnt_q, 0);
        check("async_rst_v_cnt", dut.v_cnt_q, 0);
        check("async_rst_sq_y", dut.sq_y_q, 224);
        check("async_rst_colour", dut.colour_q, 0);
        repeat (4) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2000) @(negedge sysclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
